sprite_compositor: RTL and testbench

Parametrised multi-channel sprite compositor between the VGA timing generator and the DAC output register. Each cycle it tests the current beam position against NUM_SPRITES independently positioned, scaled 1-bpp bitmaps and resolves overlaps by fixed priority. It emits one COLOR_W pixel through a 3-stage pipeline. Per-frame overlap (collision) flags for every channel are accumulated and published once per frame, replacing ad-hoc player/laser/invader collision logic.

---
 rtl/sprite_compositor.sv | 153 +++++++++++++++
 tb/tb_sprite_compositor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor
// Description : Three-stage, fixed-priority compositor for NUM_SPRITES scaled
//               1-bpp sprites with per-frame collision flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 8,
  parameter int SCALE_LOG2  = 1,
  parameter int COLOR_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               de,
  input  logic [9:0]                         px,
  input  logic [9:0]                         py,
  input  logic                               frame,
  input  logic [NUM_SPRITES-1:0]             spr_en,
  input  logic [10*NUM_SPRITES-1:0]          spr_x,
  input  logic [10*NUM_SPRITES-1:0]          spr_y,
  input  logic [COLOR_W*NUM_SPRITES-1:0]     spr_color,
  input  logic [SPR_W*SPR_H*NUM_SPRITES-1:0] spr_bitmap,
  input  logic [COLOR_W-1:0]                 bg_color,
  output logic [COLOR_W-1:0]                 pix_out,
  output logic                               pix_valid,
  output logic [NUM_SPRITES-1:0]             coll_out,
  output logic                               coll_valid
);

  localparam int BMP_BITS = SPR_W * SPR_H;
  localparam int COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int IDX_W    = (BMP_BITS > 1) ? $clog2(BMP_BITS) : 1;
  localparam logic [10:0] WIN_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] WIN_H = 11'(SPR_H << SCALE_LOG2);

  // Stage 1: window test per channel
  logic [NUM_SPRITES-1:0] win_c;
  logic [COL_W-1:0]       col_c [NUM_SPRITES];
  logic [ROW_W-1:0]       row_c [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] s1_win;
  logic [COL_W-1:0]       s1_col [NUM_SPRITES];
  logic [ROW_W-1:0]       s1_row [NUM_SPRITES];
  logic                   s1_de;
  logic                   s1_frame;

  generate
    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_win
      logic [10:0] dx;
      logic [10:0] dy;
      // 11-bit difference keeps the sign, so sprites never wrap around the screen
      assign dx = {1'b0, px} - {1'b0, spr_x[10*k +: 10]};
      assign dy = {1'b0, py} - {1'b0, spr_y[10*k +: 10]};
      assign win_c[k] = spr_en[k] && !dx[10] && (dx < WIN_W) && !dy[10] && (dy < WIN_H);
      assign col_c[k] = win_c[k] ? COL_W'(dx >> SCALE_LOG2) : '0;
      assign row_c[k] = win_c[k] ? ROW_W'(dy >> SCALE_LOG2) : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_win   <= '0;
      s1_de    <= 1'b0;
      s1_frame <= 1'b0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        s1_col[k] <= '0;
        s1_row[k] <= '0;
      end
    end else begin
      s1_win   <= win_c;
      s1_de    <= de;
      s1_frame <= frame;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        s1_col[k] <= col_c[k];
        s1_row[k] <= row_c[k];
      end
    end
  end

  // Stage 2: bitmap lookup
  logic [NUM_SPRITES-1:0] hit_c;
  logic [NUM_SPRITES-1:0] s2_hit;
  logic                   s2_de;
  logic                   s2_frame;

  generate
    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
      logic [BMP_BITS-1:0] bmp;
      logic [IDX_W-1:0]    idx;
      assign bmp      = spr_bitmap[k*BMP_BITS +: BMP_BITS];
      assign idx      = IDX_W'(s1_row[k]) * IDX_W'(SPR_W) + IDX_W'(s1_col[k]);
      assign hit_c[k] = s1_win[k] & bmp[idx];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_hit   <= '0;
      s2_de    <= 1'b0;
      s2_frame <= 1'b0;
    end else begin
      s2_hit   <= hit_c;
      s2_de    <= s1_de;
      s2_frame <= s1_frame;
    end
  end

  // Stage 3: priority resolve and collision accumulation
  logic [COLOR_W-1:0]     pix_c;
  logic [NUM_SPRITES-1:0] contrib;
  logic [NUM_SPRITES-1:0] acc;

  always_comb begin
    pix_c = bg_color;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (s2_hit[k]) pix_c = spr_color[k*COLOR_W +: COLOR_W];
    end
    if (!s2_de) pix_c = '0;
  end

  // x & (x-1) is non-zero exactly when two or more bits are set
  always_comb begin
    contrib = '0;
    if (s2_de && |(s2_hit & (s2_hit - NUM_SPRITES'(1)))) contrib = s2_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      coll_out   <= '0;
      coll_valid <= 1'b0;
      acc        <= '0;
    end else begin
      pix_out   <= pix_c;
      pix_valid <= s2_de;
      if (s2_frame) begin
        coll_out   <= acc | contrib;
        acc        <= '0;
        coll_valid <= 1'b1;
      end else begin
        acc        <= acc | contrib;
        coll_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_compositor
// Description : Table-driven, directed and randomized bench for sprite_compositor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          de;
  logic [9:0]    px;
  logic [9:0]    py;
  logic          frame;
  logic [N-1:0]  spr_en;
  logic [79:0]   spr_x;
  logic [79:0]   spr_y;
  logic [63:0]   spr_color;
  logic [1023:0] spr_bitmap;
  logic [7:0]    bg_color;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic [N-1:0]  coll_out;
  logic          coll_valid;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .de(de), .px(px), .py(py), .frame(frame),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color),
    .spr_bitmap(spr_bitmap), .bg_color(bg_color), .pix_out(pix_out),
    .pix_valid(pix_valid), .coll_out(coll_out), .coll_valid(coll_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pix;
    logic       valid;
    logic       cv;
    logic [7:0] coll;
  } exp_t;

  typedef struct {
    int         cfg;
    int         x;
    int         y;
    logic [7:0] pix;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference sprite state
  bit           m_en  [N];
  int           m_x   [N];
  int           m_y   [N];
  logic [7:0]   m_col [N];
  logic [127:0] m_bmp [N];
  logic [7:0]   m_bg;
  logic [7:0]   m_acc;
  logic [7:0]   m_coll;
  exp_t         q[$];
  vec_t         vecs [31];

  task automatic apply_cfg();
    for (int k = 0; k < N; k++) begin
      spr_en[k]               = m_en[k];
      spr_x[k*10 +: 10]       = 10'(m_x[k]);
      spr_y[k*10 +: 10]       = 10'(m_y[k]);
      spr_color[k*8 +: 8]     = m_col[k];
      spr_bitmap[k*128 +: 128] = m_bmp[k];
    end
    bg_color = m_bg;
  endtask

  task automatic set_cfg(input int id);
    for (int k = 0; k < N; k++) begin
      m_en[k] = 1'b0; m_x[k] = 0; m_y[k] = 0;
      m_col[k] = 8'(k * 16 + 1); m_bmp[k] = '0;
    end
    m_bg = 8'h00;
    case (id)
      0: begin m_en[0] = 1; m_x[0] = 100; m_y[0] = 50; m_col[0] = 8'h1C; m_bmp[0] = '1; end
      1: begin m_en[0] = 1; m_x[0] = 200; m_y[0] = 10; m_col[0] = 8'h1C; m_bmp[0][1] = 1'b1; end
      2: begin m_en[0] = 1; m_x[0] = 630; m_y[0] = 0;  m_col[0] = 8'h1C; m_bmp[0] = '1; end
      3: begin m_en[0] = 1; m_x[0] = 1000; m_y[0] = 0; m_col[0] = 8'h1C; m_bmp[0] = '1; end
      default: begin
        m_en[2] = 1; m_x[2] = 300; m_y[2] = 100; m_col[2] = 8'hE0; m_bmp[2] = '1;
        m_en[5] = 1; m_x[5] = 300; m_y[5] = 100; m_col[5] = 8'h03; m_bmp[5] = '1;
        m_bg = 8'h55;
      end
    endcase
    apply_cfg();
  endtask

  // One pixel clock: check the output due now, then present a new pixel
  task automatic step(input int x, input int y, input bit d, input bit f,
                      input bit use_tab, input logic [7:0] tab_pix);
    exp_t e;
    logic [7:0] hits, mpix, contrib;
    int dx, dy;
    bit found;
    @(negedge clk);
    if (q.size() >= 3) begin
      e = q.pop_front();
      checks++;
      if (pix_out !== e.pix || pix_valid !== e.valid || coll_valid !== e.cv || coll_out !== e.coll) begin
        failures++;
        $display("FAIL pipe t=%0t got pix=%h valid=%b cv=%b coll=%h exp pix=%h valid=%b cv=%b coll=%h",
                 $time, pix_out, pix_valid, coll_valid, coll_out, e.pix, e.valid, e.cv, e.coll);
      end
    end
    px = 10'(x); py = 10'(y); de = d; frame = f;
    hits = '0;
    for (int k = 0; k < N; k++) begin
      if (m_en[k]) begin
        dx = x - m_x[k];
        dy = y - m_y[k];
        if (dx >= 0 && dx < 32 && dy >= 0 && dy < 16)
          if (m_bmp[k][(dy / 2) * 16 + dx / 2]) hits[k] = 1'b1;
      end
    end
    mpix = m_bg; found = 0;
    for (int k = 0; k < N; k++)
      if (hits[k] && !found) begin mpix = m_col[k]; found = 1; end
    if (!d) mpix = 8'h00;
    contrib = (d && $countones(hits) >= 2) ? hits : 8'h00;
    e.cv = f;
    if (f) begin m_coll = m_acc | contrib; m_acc = '0; end
    else m_acc = m_acc | contrib;
    e.pix   = use_tab ? (d ? tab_pix : 8'h00) : mpix;
    e.valid = d;
    e.coll  = m_coll;
    q.push_back(e);
  endtask

  task automatic blank(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic restart_model();
    q.delete();
    repeat (3) q.push_back('{8'h00, 1'b0, 1'b0, 8'h00});
    m_acc = '0;
    m_coll = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cur, x, y, k;
    bit d;

    vecs[0]  = '{0, 99, 50, 8'h00};  vecs[1]  = '{0, 100, 50, 8'h1C};
    vecs[2]  = '{0, 131, 50, 8'h1C}; vecs[3]  = '{0, 132, 50, 8'h00};
    vecs[4]  = '{0, 100, 65, 8'h1C}; vecs[5]  = '{0, 100, 66, 8'h00};
    vecs[6]  = '{0, 100, 49, 8'h00}; vecs[7]  = '{0, 131, 65, 8'h1C};
    vecs[8]  = '{1, 200, 10, 8'h00}; vecs[9]  = '{1, 201, 10, 8'h00};
    vecs[10] = '{1, 202, 10, 8'h1C}; vecs[11] = '{1, 203, 11, 8'h1C};
    vecs[12] = '{1, 204, 10, 8'h00}; vecs[13] = '{1, 202, 12, 8'h00};
    vecs[14] = '{1, 203, 9, 8'h00};  vecs[15] = '{2, 629, 0, 8'h00};
    vecs[16] = '{2, 630, 0, 8'h1C};  vecs[17] = '{2, 639, 3, 8'h1C};
    vecs[18] = '{2, 0, 0, 8'h00};    vecs[19] = '{2, 21, 1, 8'h00};
    vecs[20] = '{2, 10, 15, 8'h00};  vecs[21] = '{3, 0, 0, 8'h00};
    vecs[22] = '{3, 7, 3, 8'h00};    vecs[23] = '{3, 23, 3, 8'h00};
    vecs[24] = '{3, 639, 0, 8'h00};  vecs[25] = '{4, 300, 100, 8'hE0};
    vecs[26] = '{4, 331, 115, 8'hE0}; vecs[27] = '{4, 315, 107, 8'hE0};
    vecs[28] = '{4, 299, 100, 8'h55}; vecs[29] = '{4, 332, 115, 8'h55};
    vecs[30] = '{4, 300, 116, 8'h55};

    rst = 1'b1; de = 0; frame = 0; px = 0; py = 0;
    set_cfg(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    restart_model();

    // Table-driven probes
    cur = -1;
    for (int i = 0; i < 31; i++) begin
      if (vecs[i].cfg != cur) begin
        blank(4);
        set_cfg(vecs[i].cfg);
        cur = vecs[i].cfg;
      end
      step(vecs[i].x, vecs[i].y, 1, 0, 1, vecs[i].pix);
    end

    // Collision from the priority probes is published on the next frame
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_prio", coll_out, 8'h24);

    // ch5 disabled: next frame publishes nothing
    blank(4);
    m_en[5] = 0; apply_cfg();
    for (int i = 0; i < 4; i++) step(305 + i, 104, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_ch5_off", coll_out, 8'h00);

    // Frame pulse coinciding with a collision pixel
    m_en[5] = 1; apply_cfg();
    blank(4);
    step(310, 105, 1, 1, 0, 8'h00);
    blank(4);
    check8("coll_same_cycle", coll_out, 8'h24);

    // Back-to-back frame pulses
    step(310, 105, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_back_to_back", coll_out, 8'h00);

    // Overlap only during blanking
    for (int i = 0; i < 3; i++) step(310, 105 + i, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_blank", coll_out, 8'h00);

    // Transparent bits over another sprite
    m_bmp[5] = '0; apply_cfg();
    blank(4);
    for (int i = 0; i < 3; i++) step(310 + i, 105, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_transparent", coll_out, 8'h00);

    // Asynchronous reset with lit pixels and pending collisions
    m_bmp[5] = '1; apply_cfg();
    blank(4);
    for (int i = 0; i < 5; i++) step(300 + i, 100, 1, 0, 0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check8("rst_pix", pix_out, 8'h00);
    check8("rst_valid", {7'd0, pix_valid}, 8'h00);
    check8("rst_coll", coll_out, 8'h00);
    check8("rst_cv", {7'd0, coll_valid}, 8'h00);
    @(negedge clk);
    de = 0; frame = 0; px = 0; py = 0;
    @(negedge clk);
    rst = 1'b0;
    restart_model();
    step(0, 0, 0, 1, 0, 8'h00);
    blank(4);
    check8("coll_after_rst", coll_out, 8'h00);

    // Randomized configurations against the reference model
    for (int r = 0; r < 6; r++) begin
      blank(4);
      for (int j = 0; j < N; j++) begin
        m_en[j]  = ($urandom_range(0, 3) != 0);
        m_x[j]   = ($urandom_range(0, 9) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 150);
        m_y[j]   = $urandom_range(0, 40);
        m_col[j] = 8'($urandom);
        for (int w = 0; w < 4; w++) m_bmp[j][w*32 +: 32] = $urandom;
      end
      m_bg = 8'($urandom);
      apply_cfg();
      for (int i = 0; i < 300; i++) begin
        k = $urandom_range(0, N - 1);
        x = m_x[k] + $urandom_range(0, 34) - 1;
        y = m_y[k] + $urandom_range(0, 18) - 1;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        d = (x < 640) && ($urandom_range(0, 7) != 0);
        step(x, y, d, ($urandom_range(0, 39) == 0), 0, 8'h00);
      end
    end
    blank(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
